// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, operand-2 generation, ALU with NZCV status,
// branch target, and the EXE/MEM pipeline register.
module exe_stage #(
   parameter int DW     = 32,
   parameter int RST_PC = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          freeze,
   input  logic          wb_en_in,
   input  logic          mem_r_en_in,
   input  logic          mem_w_en_in,
   input  logic          b_in,
   input  logic          s_in,
   input  logic [3:0]    exe_cmd,
   input  logic [DW-1:0] pc_in,
   input  logic [DW-1:0] val_rn,
   input  logic [DW-1:0] val_rm,
   input  logic          imm,
   input  logic [11:0]   shift_operand,
   input  logic [23:0]   signed_imm_24,
   input  logic [3:0]    dest_in,
   input  logic [1:0]    sel_src1,
   input  logic [1:0]    sel_src2,
   input  logic [DW-1:0] mem_fwd_val,
   input  logic [DW-1:0] wb_fwd_val,
   output logic          wb_en,
   output logic          mem_r_en,
   output logic          mem_w_en,
   output logic [DW-1:0] alu_res,
   output logic [DW-1:0] st_val,
   output logic [3:0]    dest,
   output logic [3:0]    status,
   output logic          branch_taken,
   output logic [DW-1:0] branch_addr
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   // Kept for interface compatibility; it does not influence any logic.
   localparam logic [31:0] RST_PC_V = 32'(RST_PC);
   logic unused_rst_pc;
   assign unused_rst_pc = ^RST_PC_V;

   logic [DW-1:0] rn_fwd;
   logic [DW-1:0] rm_fwd;
   logic [DW-1:0] imm_base;
   logic [4:0]    imm_rot;
   logic [DW-1:0] imm_val;
   logic [4:0]    sh_amt;
   logic [DW-1:0] val2;
   logic [DW-1:0] op_b;
   logic          cin;
   logic          arith;
   logic          valid_cmd;
   logic [DW:0]   sum;
   logic [DW-1:0] alu_out;
   logic [3:0]    flags_nxt;

   always_comb begin
      case (sel_src1)
         2'b01:   rn_fwd = mem_fwd_val;
         2'b10:   rn_fwd = wb_fwd_val;
         default: rn_fwd = val_rn;
      endcase
      case (sel_src2)
         2'b01:   rm_fwd = mem_fwd_val;
         2'b10:   rm_fwd = wb_fwd_val;
         default: rm_fwd = val_rm;
      endcase
   end

   // A shift by the full width yields zero, so a zero rotate passes the value through.
   assign imm_base = {{(DW-8){1'b0}}, shift_operand[7:0]};
   assign imm_rot  = {shift_operand[11:8], 1'b0};
   assign imm_val  = (imm_base >> imm_rot) | (imm_base << (DW - int'(imm_rot)));
   assign sh_amt   = shift_operand[11:7];

   always_comb begin
      val2 = rm_fwd;
      if (imm) begin
         val2 = imm_val;
      end else if (mem_r_en_in || mem_w_en_in) begin
         val2 = {{(DW-12){1'b0}}, shift_operand};
      end else begin
         case (shift_operand[6:5])
            2'b00:   val2 = rm_fwd << sh_amt;
            2'b01:   val2 = rm_fwd >> sh_amt;
            2'b10:   val2 = $signed(rm_fwd) >>> sh_amt;
            default: val2 = (rm_fwd >> sh_amt) | (rm_fwd << (DW - int'(sh_amt)));
         endcase
      end
   end

   // Subtraction is done as rn + ~v2 + cin so the adder carry is the no-borrow flag.
   always_comb begin
      op_b      = val2;
      cin       = 1'b0;
      arith     = 1'b0;
      valid_cmd = 1'b1;
      alu_out   = '0;
      flags_nxt = status;
      case (exe_cmd)
         CMD_MOV: alu_out = val2;
         CMD_MVN: alu_out = ~val2;
         CMD_ADD: arith = 1'b1;
         CMD_ADC: begin
            arith = 1'b1;
            cin   = status[1];
         end
         CMD_SUB: begin
            arith = 1'b1;
            op_b  = ~val2;
            cin   = 1'b1;
         end
         CMD_SBC: begin
            arith = 1'b1;
            op_b  = ~val2;
            cin   = status[1];
         end
         CMD_AND: alu_out = rn_fwd & val2;
         CMD_ORR: alu_out = rn_fwd | val2;
         CMD_EOR: alu_out = rn_fwd ^ val2;
         default: valid_cmd = 1'b0;
      endcase
      sum = {1'b0, rn_fwd} + {1'b0, op_b} + {{DW{1'b0}}, cin};
      if (arith) begin
         alu_out = sum[DW-1:0];
      end
      if (valid_cmd) begin
         flags_nxt[3] = alu_out[DW-1];
         flags_nxt[2] = (alu_out == '0);
         if (arith) begin
            flags_nxt[1] = sum[DW];
            flags_nxt[0] = (rn_fwd[DW-1] == op_b[DW-1]) && (alu_out[DW-1] != rn_fwd[DW-1]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status <= '0;
      end else if (s_in && !freeze) begin
         status <= flags_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en    <= 1'b0;
         mem_r_en <= 1'b0;
         mem_w_en <= 1'b0;
         alu_res  <= '0;
         st_val   <= '0;
         dest     <= '0;
      end else if (!freeze) begin
         wb_en    <= wb_en_in;
         mem_r_en <= mem_r_en_in;
         mem_w_en <= mem_w_en_in;
         alu_res  <= alu_out;
         st_val   <= rm_fwd;
         dest     <= dest_in;
      end
   end

   // The fetch stage is responsible for ignoring a branch while frozen.
   assign branch_taken = b_in;
   assign branch_addr  = pc_in + {{(DW-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios plus randomized traffic checked against
// an arithmetic reference model of the execute stage.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm;
   logic [3:0]  exe_cmd, dest_in;
   logic [31:0] pc_in, val_rn, val_rm, mem_fwd_val, wb_fwd_val;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm_24;
   logic [1:0]  sel_src1, sel_src2;

   logic        wb_en, mem_r_en, mem_w_en, branch_taken;
   logic [31:0] alu_res, st_val, branch_addr;
   logic [3:0]  dest, status;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected registered state
   logic        e_wb, e_mr, e_mw;
   logic [31:0] e_res, e_st;
   logic [3:0]  e_dest, e_stat;

   logic [31:0] corner [4] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

   exe_stage #(.DW(32), .RST_PC(0)) dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .b_in(b_in), .s_in(s_in), .exe_cmd(exe_cmd), .pc_in(pc_in),
      .val_rn(val_rn), .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
      .signed_imm_24(signed_imm_24), .dest_in(dest_in),
      .sel_src1(sel_src1), .sel_src2(sel_src2),
      .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
      .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .alu_res(alu_res), .st_val(st_val), .dest(dest), .status(status),
      .branch_taken(branch_taken), .branch_addr(branch_addr)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      freeze = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
      imm = 0; exe_cmd = 0; dest_in = 0; pc_in = 0; val_rn = 0; val_rm = 0;
      mem_fwd_val = 0; wb_fwd_val = 0; shift_operand = 0; signed_imm_24 = 0;
      sel_src1 = 0; sel_src2 = 0;
   endtask

   task automatic model_clear();
      e_wb = 0; e_mr = 0; e_mw = 0; e_res = 0; e_st = 0; e_dest = 0; e_stat = 0;
   endtask

   function automatic logic [31:0] pick_val();
      logic [31:0] v;
      if ($urandom_range(0, 3) == 0) v = corner[$urandom_range(0, 3)];
      else v = $urandom;
      return v;
   endfunction

   task automatic randomize_inputs();
      wb_en_in = 1'($urandom); b_in = 1'($urandom); s_in = 1'($urandom);
      imm = 1'($urandom);
      mem_r_en_in = ($urandom_range(0, 3) == 0);
      mem_w_en_in = ($urandom_range(0, 3) == 0);
      exe_cmd = 4'($urandom); dest_in = 4'($urandom);
      pc_in = $urandom; val_rn = pick_val(); val_rm = pick_val();
      mem_fwd_val = pick_val(); wb_fwd_val = pick_val();
      shift_operand = 12'($urandom); signed_imm_24 = 24'($urandom);
      sel_src1 = 2'($urandom); sel_src2 = 2'($urandom);
   endtask

   function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] r);
      if (s == 2'b01) return mem_fwd_val;
      if (s == 2'b10) return wb_fwd_val;
      return r;
   endfunction

   function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
      logic [31:0] r;
      if (n == 0) r = x;
      else r = (x >> n) | (x << (32 - n));
      return r;
   endfunction

   function automatic logic [31:0] m_branch();
      longint off;
      longint t;
      off = longint'({40'b0, signed_imm_24});
      if (off >= 64'sd8388608) off = off - 64'sd16777216;
      t = longint'({32'b0, pc_in}) + off * 4;
      return t[31:0];
   endfunction

   // Result and flags from the instruction semantics, using wide integer arithmetic.
   task automatic m_eval(output logic [31:0] r, output logic [3:0] f);
      logic [31:0] a, rm, v2;
      logic signed [31:0] t;
      longint ua, ub, sa, sb, us, ss;
      int n, cb;
      logic c, v;
      a  = m_fwd(sel_src1, val_rn);
      rm = m_fwd(sel_src2, val_rm);
      if (imm) v2 = m_rotr({24'b0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8]));
      else if (mem_r_en_in || mem_w_en_in) v2 = {20'b0, shift_operand};
      else begin
         n = int'(shift_operand[11:7]);
         case (shift_operand[6:5])
            2'd0: v2 = rm << n;
            2'd1: v2 = rm >> n;
            2'd2: begin t = rm; v2 = t >>> n; end
            default: v2 = m_rotr(rm, n);
         endcase
      end
      ua = longint'({32'b0, a});  ub = longint'({32'b0, v2});
      sa = longint'($signed(a));  sb = longint'($signed(v2));
      cb = int'(e_stat[1]);
      f = e_stat; r = 0; c = e_stat[1]; v = e_stat[0]; us = 0; ss = 0;
      case (exe_cmd)
         4'd1: r = v2;
         4'd9: r = ~v2;
         4'd6: r = a & v2;
         4'd7: r = a | v2;
         4'd8: r = a ^ v2;
         4'd2, 4'd3: begin
            us = ua + ub + ((exe_cmd == 4'd3) ? cb : 0);
            ss = sa + sb + ((exe_cmd == 4'd3) ? cb : 0);
            c  = (us > 64'sh0000_0000_FFFF_FFFF);
         end
         4'd4, 4'd5: begin
            us = ua - ub - ((exe_cmd == 4'd5) ? (1 - cb) : 0);
            ss = sa - sb - ((exe_cmd == 4'd5) ? (1 - cb) : 0);
            c  = (ua >= ub + ((exe_cmd == 4'd5) ? (1 - cb) : 0));
         end
         default: ;
      endcase
      if (exe_cmd inside {4'd2, 4'd3, 4'd4, 4'd5}) begin
         r = us[31:0];
         v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         f = {r[31], (r == 32'd0), c, v};
      end else if (exe_cmd inside {4'd1, 4'd9, 4'd6, 4'd7, 4'd8}) begin
         f = {r[31], (r == 32'd0), e_stat[1], e_stat[0]};
      end
   endtask

   // Advance the expected state for the coming edge (call before the edge).
   task automatic model_step();
      logic [31:0] r;
      logic [3:0]  f;
      m_eval(r, f);
      if (!freeze) begin
         e_wb = wb_en_in; e_mr = mem_r_en_in; e_mw = mem_w_en_in;
         e_res = r; e_st = m_fwd(sel_src2, val_rm); e_dest = dest_in;
      end
      if (s_in && !freeze) e_stat = f;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; clear_inputs(); model_clear();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (alu_res !== 32'd0) begin n_fail++; $display("FAIL reset_alu_res got=%h exp=0", alu_res); end
      n_checks++; if (st_val !== 32'd0) begin n_fail++; $display("FAIL reset_st_val got=%h exp=0", st_val); end
      n_checks++; if ({wb_en, mem_r_en, mem_w_en, dest} !== 7'd0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {wb_en, mem_r_en, mem_w_en, dest}); end
      n_checks++; if (status !== 4'd0) begin n_fail++; $display("FAIL reset_status got=%b exp=0000", status); end
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_flags();
      clear_inputs();
      val_rn = 32'h7FFF_FFFF; imm = 1; shift_operand = 12'h001; exe_cmd = 4'b0010;
      s_in = 1; wb_en_in = 1; dest_in = 4'd3;
      tick();
      n_checks++; if (alu_res !== 32'h8000_0000) begin n_fail++; $display("FAIL add_res got=%h exp=80000000", alu_res); end
      n_checks++; if (status !== 4'b1001) begin n_fail++; $display("FAIL add_status got=%b exp=1001", status); end
      n_checks++; if ({wb_en, dest} !== 5'b1_0011) begin n_fail++; $display("FAIL add_ctrl got=%b exp=10011", {wb_en, dest}); end
   endtask

   task automatic test_sub_shift();
      clear_inputs();
      val_rn = 32'd5; val_rm = 32'd3; shift_operand = {5'd1, 2'b00, 5'd0};
      exe_cmd = 4'b0100; s_in = 1;
      tick();
      n_checks++; if (alu_res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub_res got=%h exp=ffffffff", alu_res); end
      n_checks++; if (status !== 4'b1000) begin n_fail++; $display("FAIL sub_status got=%b exp=1000", status); end
   endtask

   task automatic test_mem_fwd();
      clear_inputs();
      mem_r_en_in = 1; shift_operand = 12'h804; sel_src1 = 2'b01; mem_fwd_val = 32'h100;
      val_rn = 32'hDEAD; exe_cmd = 4'b0010; sel_src2 = 2'b10; wb_fwd_val = 32'h1234_CAFE;
      val_rm = 32'h11; dest_in = 4'd9;
      tick();
      n_checks++; if (alu_res !== 32'h904) begin n_fail++; $display("FAIL memfwd_res got=%h exp=00000904", alu_res); end
      n_checks++; if (st_val !== 32'h1234_CAFE) begin n_fail++; $display("FAIL memfwd_st got=%h exp=1234cafe", st_val); end
      n_checks++; if ({mem_r_en, mem_w_en, dest} !== 6'b10_1001) begin n_fail++; $display("FAIL memfwd_ctrl got=%b exp=101001", {mem_r_en, mem_w_en, dest}); end
      n_checks++; if (status !== 4'b1000) begin n_fail++; $display("FAIL memfwd_status got=%b exp=1000", status); end
      // Select 11 behaves as the register-file value
      clear_inputs();
      sel_src1 = 2'b11; val_rn = 32'h10; mem_fwd_val = 32'h5000; wb_fwd_val = 32'h6000;
      imm = 1; shift_operand = 12'h0FF; exe_cmd = 4'b0010;
      sel_src2 = 2'b11; val_rm = 32'hABCD;
      tick();
      n_checks++; if (alu_res !== 32'h10F) begin n_fail++; $display("FAIL sel11_res got=%h exp=0000010f", alu_res); end
      n_checks++; if (st_val !== 32'hABCD) begin n_fail++; $display("FAIL sel11_st got=%h exp=0000abcd", st_val); end
   endtask

   task automatic test_freeze();
      for (int i = 0; i < 3; i++) begin
         randomize_inputs();
         freeze = 1; s_in = 1; exe_cmd = 4'b0010;
         tick();
         n_checks++; if (alu_res !== 32'h10F) begin n_fail++; $display("FAIL freeze_res cyc=%0d got=%h exp=0000010f", i, alu_res); end
         n_checks++; if (st_val !== 32'hABCD) begin n_fail++; $display("FAIL freeze_st cyc=%0d got=%h exp=0000abcd", i, st_val); end
         n_checks++; if (status !== 4'b1000) begin n_fail++; $display("FAIL freeze_status cyc=%0d got=%b exp=1000", i, status); end
         n_checks++; if ({wb_en, mem_r_en, mem_w_en, dest} !== 7'd0) begin n_fail++; $display("FAIL freeze_ctrl cyc=%0d got=%b exp=0", i, {wb_en, mem_r_en, mem_w_en, dest}); end
      end
      clear_inputs();
      val_rn = 32'd1; imm = 1; shift_operand = 12'h002; exe_cmd = 4'b0010; s_in = 1;
      wb_en_in = 1; dest_in = 4'd7;
      tick();
      n_checks++; if (alu_res !== 32'd3) begin n_fail++; $display("FAIL unfreeze_res got=%h exp=00000003", alu_res); end
      n_checks++; if (status !== 4'b0000) begin n_fail++; $display("FAIL unfreeze_status got=%b exp=0000", status); end
      n_checks++; if ({wb_en, dest} !== 5'b1_0111) begin n_fail++; $display("FAIL unfreeze_ctrl got=%b exp=10111", {wb_en, dest}); end
   endtask

   task automatic test_branch();
      clear_inputs();
      pc_in = 32'h20; signed_imm_24 = 24'hFFFFFE; b_in = 1;
      #1;
      n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL br_taken got=%b exp=1", branch_taken); end
      n_checks++; if (branch_addr !== 32'h18) begin n_fail++; $display("FAIL br_addr got=%h exp=00000018", branch_addr); end
      freeze = 1; pc_in = 32'h1000; signed_imm_24 = 24'h000010;
      #1;
      n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL br_taken_frozen got=%b exp=1", branch_taken); end
      n_checks++; if (branch_addr !== 32'h1040) begin n_fail++; $display("FAIL br_addr_fwd got=%h exp=00001040", branch_addr); end
      tick();
      b_in = 0; freeze = 0;
      #1;
      n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL br_not_taken got=%b exp=0", branch_taken); end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] exp_addr;
      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         freeze = ($urandom_range(0, 4) == 0);
         exp_addr = m_branch();
         #1;
         n_checks++; if ({branch_taken, branch_addr} !== {b_in, exp_addr}) begin n_fail++; $display("FAIL rnd_branch it=%0d got=%b/%h exp=%b/%h", i, branch_taken, branch_addr, b_in, exp_addr); end
         tick();
         n_checks++; if (alu_res !== e_res) begin n_fail++; $display("FAIL rnd_res it=%0d cmd=%h got=%h exp=%h", i, exe_cmd, alu_res, e_res); end
         n_checks++; if (st_val !== e_st) begin n_fail++; $display("FAIL rnd_st it=%0d got=%h exp=%h", i, st_val, e_st); end
         n_checks++; if ({wb_en, mem_r_en, mem_w_en, dest} !== {e_wb, e_mr, e_mw, e_dest}) begin n_fail++; $display("FAIL rnd_ctrl it=%0d got=%b exp=%b", i, {wb_en, mem_r_en, mem_w_en, dest}, {e_wb, e_mr, e_mw, e_dest}); end
         n_checks++; if (status !== e_stat) begin n_fail++; $display("FAIL rnd_status it=%0d cmd=%h got=%b exp=%b", i, exe_cmd, status, e_stat); end
      end
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      val_rn = 32'h7FFF_FFFF; imm = 1; shift_operand = 12'h001; exe_cmd = 4'b0010;
      s_in = 1; wb_en_in = 1; dest_in = 4'd5; val_rm = 32'h55AA;
      tick();
      randomize_inputs();
      rst = 1;
      #2;
      n_checks++; if ({alu_res, st_val} !== 64'd0) begin n_fail++; $display("FAIL midrst_data got=%h/%h exp=0/0", alu_res, st_val); end
      n_checks++; if ({wb_en, mem_r_en, mem_w_en, dest, status} !== 11'd0) begin n_fail++; $display("FAIL midrst_ctrl got=%b exp=0", {wb_en, mem_r_en, mem_w_en, dest, status}); end
      @(posedge clk); #1;
      n_checks++; if ({alu_res, status, dest} !== 40'd0) begin n_fail++; $display("FAIL rst_hold got=%h/%b/%h exp=0", alu_res, status, dest); end
      rst = 0; clear_inputs(); model_clear();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      model_clear();
      test_reset();
      test_add_flags();
      test_sub_shift();
      test_mem_fwd();
      test_freeze();
      test_branch();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
